// File: rtl/dispatch_pkg.sv
// Shared types for the dispatch stage: opcode classes, FSM states, instruction record.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
// Contents: OP_NOP bubble opcode, op_cls_e, state_e, instr_t, INSTR_IDLE, op_class().
package dispatch_pkg;

   localparam logic [4:0] OP_NOP = 5'b11111;

   typedef enum logic [1:0] {CLS_ALU, CLS_LSU, CLS_NONE} op_cls_e;

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;

   typedef struct packed {
      logic [4:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        has_imm;
   } instr_t;

   localparam instr_t INSTR_IDLE = '{op: OP_NOP, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                                     imm: 32'd0, has_imm: 1'b0};

   // 0-11 ALU, 12-19 load/store, 20-30 branch/system (executed by the ALU), 31 bubble.
   function automatic op_cls_e op_class(input logic [4:0] op);
      if (op <= 5'd11)      return CLS_ALU;
      else if (op <= 5'd19) return CLS_LSU;
      else if (op <= 5'd30) return CLS_ALU;
      return CLS_NONE;
   endfunction

endpackage

// File: rtl/credit_counter.sv
// Credit counter for one downstream resource; resets/clears to DEPTH credits.
// Latency: count updates on the clock edge after inc/dec/clr.
// Backpressure: none; zero flags an exhausted resource, err latches an over-release.
// Ports: clk, rst_n (sync, active-low), inc (+1), dec (-1), clr (back to DEPTH),
//        cnt (current credits), zero (cnt == 0), err (sticky over-release).
module credit_counter #(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          dec,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          zero,
   output logic          err
);

   localparam logic [CW-1:0] MAX = CW'(DEPTH);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   // clr discards a same-cycle inc, so a release racing a flush never flags err.
   // inc and dec together cancel, even at MAX.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (clr) begin
         cnt_d = MAX;
      end else if (inc && !dec) begin
         if (cnt_q == MAX) err_d = 1'b1;
         else              cnt_d = cnt_q + CW'(1);
      end else if (dec && !inc) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= MAX;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);
   assign err  = err_q;

endmodule

// File: rtl/dispatch_scheduler.sv
// Pops decoded instructions from the IQ head and dispatches them to the ALU RS or LSB with a ROB tag.
// Latency: an instruction accepted at edge N dispatches (dsp_valid) at edge N+1 at the earliest.
// Backpressure: iq_ready drops when the hold slot cannot drain (missing ROB/RS/LSB credit), on pause and around flush.
// Ports: clk, rst_n, pause, flush; iq_* instruction in with iq_ready; rob_commit/rs_release/lsb_release credit returns;
//        dsp_* registered dispatch out; rob_full, rs_full, credit_err status.
module dispatch_scheduler
   import dispatch_pkg::*;
#(
   parameter int  ROB_DEPTH = 16,
   parameter int  RS_DEPTH  = 8,
   parameter int  LSB_DEPTH = 8,
   localparam int TW        = $clog2(ROB_DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pause,
   input  logic          flush,
   input  logic          iq_valid,
   input  logic [4:0]    iq_op,
   input  logic [4:0]    iq_rs1,
   input  logic [4:0]    iq_rs2,
   input  logic [4:0]    iq_rd,
   input  logic [31:0]   iq_imm,
   input  logic          iq_has_imm,
   output logic          iq_ready,
   input  logic          rob_commit,
   input  logic          rs_release,
   input  logic          lsb_release,
   output logic          dsp_valid,
   output logic          dsp_target,
   output logic [4:0]    dsp_op,
   output logic [4:0]    dsp_rs1,
   output logic [4:0]    dsp_rs2,
   output logic [4:0]    dsp_rd,
   output logic [31:0]   dsp_imm,
   output logic          dsp_has_imm,
   output logic [TW-1:0] dsp_rob_tag,
   output logic          rob_full,
   output logic          rs_full,
   output logic          credit_err
);

   localparam int ROB_CW = $clog2(ROB_DEPTH + 1);
   localparam int RS_CW  = $clog2(RS_DEPTH + 1);
   localparam int LSB_CW = $clog2(LSB_DEPTH + 1);

   state_e        state_q, state_d;
   instr_t        hold_q, hold_d;
   logic          hold_v_q, hold_v_d;
   logic [TW-1:0] tag_q, tag_d;
   instr_t        dsp_q, dsp_d;
   logic          dsp_valid_q, dsp_valid_d;
   logic          dsp_target_q, dsp_target_d;
   logic [TW-1:0] dsp_tag_q, dsp_tag_d;

   logic [ROB_CW-1:0] rob_cnt;
   logic [RS_CW-1:0]  rs_cnt;
   logic [LSB_CW-1:0] lsb_cnt;
   logic              rob_zero, rs_zero, lsb_zero;
   logic              rob_err, rs_err, lsb_err;

   instr_t  iq_instr;
   op_cls_e hold_cls;
   logic    can_issue, issue, accept;

   assign iq_instr = '{op: iq_op, rs1: iq_rs1, rs2: iq_rs2, rd: iq_rd,
                       imm: iq_imm, has_imm: iq_has_imm};

   assign hold_cls  = op_class(hold_q.op);
   assign can_issue = hold_v_q && (rob_cnt != '0) &&
                      ((hold_cls == CLS_ALU) ? (rs_cnt != '0)
                                             : ((hold_cls == CLS_LSU) && (lsb_cnt != '0)));
   // Issue is also allowed from STALL: the edge that leaves STALL is the dispatch edge.
   assign issue    = can_issue && !pause && !flush && (state_q != FLUSH);
   assign iq_ready = !pause && (state_q == RUN) && !flush && (!hold_v_q || issue);
   assign accept   = iq_ready && iq_valid && (iq_op != OP_NOP);

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_v_d     = hold_v_q;
      tag_d        = tag_q;
      dsp_d        = dsp_q;
      dsp_valid_d  = dsp_valid_q;
      dsp_target_d = dsp_target_q;
      dsp_tag_d    = dsp_tag_q;
      if (flush) begin
         state_d     = FLUSH;
         hold_v_d    = 1'b0;
         tag_d       = '0;
         dsp_valid_d = 1'b0;
         dsp_d.op    = OP_NOP;
      end else if (!pause) begin
         unique case (state_q)
            RUN:     if (hold_v_q && !can_issue) state_d = STALL;
            STALL:   if (can_issue)              state_d = RUN;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
         endcase
         if (accept) begin
            hold_d   = iq_instr;
            hold_v_d = 1'b1;
         end else if (issue) begin
            hold_v_d = 1'b0;
         end
         if (issue) begin
            dsp_valid_d  = 1'b1;
            dsp_d        = hold_q;
            dsp_target_d = (hold_cls == CLS_LSU);
            dsp_tag_d    = tag_q;
            tag_d        = (tag_q == TW'(ROB_DEPTH - 1)) ? '0 : tag_q + TW'(1);
         end else begin
            dsp_valid_d = 1'b0;
            dsp_d.op    = OP_NOP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= RUN;
         hold_q       <= INSTR_IDLE;
         hold_v_q     <= 1'b0;
         tag_q        <= '0;
         dsp_q        <= INSTR_IDLE;
         dsp_valid_q  <= 1'b0;
         dsp_target_q <= 1'b0;
         dsp_tag_q    <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_v_q     <= hold_v_d;
         tag_q        <= tag_d;
         dsp_q        <= dsp_d;
         dsp_valid_q  <= dsp_valid_d;
         dsp_target_q <= dsp_target_d;
         dsp_tag_q    <= dsp_tag_d;
      end
   end

   credit_counter #(.DEPTH(ROB_DEPTH)) u_rob_cr (
      .clk(clk), .rst_n(rst_n), .inc(rob_commit), .dec(issue), .clr(flush),
      .cnt(rob_cnt), .zero(rob_zero), .err(rob_err));

   credit_counter #(.DEPTH(RS_DEPTH)) u_rs_cr (
      .clk(clk), .rst_n(rst_n), .inc(rs_release), .dec(issue && (hold_cls == CLS_ALU)),
      .clr(flush), .cnt(rs_cnt), .zero(rs_zero), .err(rs_err));

   credit_counter #(.DEPTH(LSB_DEPTH)) u_lsb_cr (
      .clk(clk), .rst_n(rst_n), .inc(lsb_release), .dec(issue && (hold_cls == CLS_LSU)),
      .clr(flush), .cnt(lsb_cnt), .zero(lsb_zero), .err(lsb_err));

   assign dsp_valid   = dsp_valid_q;
   assign dsp_target  = dsp_target_q;
   assign dsp_op      = dsp_q.op;
   assign dsp_rs1     = dsp_q.rs1;
   assign dsp_rs2     = dsp_q.rs2;
   assign dsp_rd      = dsp_q.rd;
   assign dsp_imm     = dsp_q.imm;
   assign dsp_has_imm = dsp_q.has_imm;
   assign dsp_rob_tag = dsp_tag_q;
   assign rob_full    = rob_zero;
   assign rs_full     = rs_zero || lsb_zero;
   assign credit_err  = rob_err || rs_err || lsb_err;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler with an in-order expected-dispatch queue.
// Latency: dispatch expected one edge after acceptance.
// Backpressure: iq_ready sampled before each edge to decide acceptance.
module tb_dispatch_scheduler;

   localparam logic [4:0] NOP = 5'b11111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pause = 1'b0, flush = 1'b0;
   logic        iq_valid = 1'b0;
   logic [4:0]  iq_op = NOP, iq_rs1 = '0, iq_rs2 = '0, iq_rd = '0;
   logic [31:0] iq_imm = '0;
   logic        iq_has_imm = 1'b0;
   logic        iq_ready;
   logic        rob_commit = 1'b0, rs_release = 1'b0, lsb_release = 1'b0;
   logic        dsp_valid, dsp_target, dsp_has_imm;
   logic [4:0]  dsp_op, dsp_rs1, dsp_rs2, dsp_rd;
   logic [31:0] dsp_imm;
   logic [3:0]  dsp_rob_tag;
   logic        rob_full, rs_full, credit_err;

   always #5 clk = ~clk;

   dispatch_scheduler u_dut (
      .clk(clk), .rst_n(rst_n), .pause(pause), .flush(flush),
      .iq_valid(iq_valid), .iq_op(iq_op), .iq_rs1(iq_rs1), .iq_rs2(iq_rs2), .iq_rd(iq_rd),
      .iq_imm(iq_imm), .iq_has_imm(iq_has_imm), .iq_ready(iq_ready),
      .rob_commit(rob_commit), .rs_release(rs_release), .lsb_release(lsb_release),
      .dsp_valid(dsp_valid), .dsp_target(dsp_target), .dsp_op(dsp_op), .dsp_rs1(dsp_rs1),
      .dsp_rs2(dsp_rs2), .dsp_rd(dsp_rd), .dsp_imm(dsp_imm), .dsp_has_imm(dsp_has_imm),
      .dsp_rob_tag(dsp_rob_tag), .rob_full(rob_full), .rs_full(rs_full), .credit_err(credit_err));

   typedef struct packed {
      logic [4:0]  op, rs1, rs2, rd;
      logic [31:0] imm;
      logic        has_imm, tgt;
      logic [3:0]  tag;
   } exp_t;

   exp_t sb[$];
   int checks = 0, errors = 0;
   int cyc = 0, disp_cnt = 0, first_disp_cyc = -1, last_disp_cyc = -1, exp_tag = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Dispatch monitor: every dsp_valid pulse must match the oldest accepted instruction.
   exp_t m;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (dsp_valid === 1'b1) begin
            disp_cnt++;
            if (first_disp_cyc < 0) first_disp_cyc = cyc;
            last_disp_cyc = cyc;
            if (sb.size() == 0) begin
               check("unexpected_dispatch", 32'd1, 32'd0);
            end else begin
               m = sb.pop_front();
               check("dsp_op", dsp_op, m.op);
               check("dsp_rs1", dsp_rs1, m.rs1);
               check("dsp_rs2", dsp_rs2, m.rs2);
               check("dsp_rd", dsp_rd, m.rd);
               check("dsp_imm", dsp_imm, m.imm);
               check("dsp_has_imm", dsp_has_imm, m.has_imm);
               check("dsp_target", dsp_target, m.tgt);
               check("dsp_rob_tag", dsp_rob_tag, m.tag);
            end
         end else begin
            check("idle_dsp_op", dsp_op, NOP);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; pause = 1'b0; flush = 1'b0; iq_valid = 1'b0; iq_op = NOP;
      rob_commit = 1'b0; rs_release = 1'b0; lsb_release = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      exp_tag = 0; disp_cnt = 0; first_disp_cyc = -1; last_disp_cyc = -1;
      #1;
   endtask

   // Presents one instruction until accepted or the budget runs out; pushes the expectation on accept.
   task automatic send(input logic [4:0] op, input logic [4:0] rd, input int budget, output bit acc);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      iq_valid = 1'b1; iq_op = op; iq_rd = rd; iq_rs1 = rd + 5'd1; iq_rs2 = rd + 5'd2;
      iq_imm = 32'h1234_0000 | {27'd0, rd}; iq_has_imm = rd[0];
      #1;
      while (iq_ready !== 1'b1 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      acc = (iq_ready === 1'b1);
      if (acc) begin
         e.op = op; e.rd = rd; e.rs1 = rd + 5'd1; e.rs2 = rd + 5'd2;
         e.imm = 32'h1234_0000 | {27'd0, rd}; e.has_imm = rd[0];
         e.tgt = (op >= 5'd12 && op <= 5'd19);
         e.tag = 4'(exp_tag);
         exp_tag = (exp_tag + 1) % 16;
         sb.push_back(e);
         @(posedge clk);
         #1;
      end
      iq_valid = 1'b0; iq_op = NOP;
   endtask

   task automatic pulse(input bit rs, input bit lsb, input bit com, input bit fl);
      @(negedge clk);
      rs_release = rs; lsb_release = lsb; rob_commit = com; flush = fl;
      @(posedge clk);
      #1;
      rs_release = 1'b0; lsb_release = 1'b0; rob_commit = 1'b0; flush = 1'b0;
   endtask

   task automatic wait_disp(input int target, input int budget, input string name);
      int n = 0;
      while (disp_cnt < target && n < budget) begin
         step();
         n++;
      end
      check(name, disp_cnt, target);
   endtask

   initial begin
      bit acc;
      int acc_cyc;

      // 1: reset state, then 4 back-to-back ALU ops
      do_reset();
      check("rst_iq_ready", iq_ready, 1'b1);
      check("rst_dsp_valid", dsp_valid, 1'b0);
      check("rst_dsp_op", dsp_op, NOP);
      check("rst_dsp_tag", dsp_rob_tag, 4'd0);
      check("rst_dsp_rd", dsp_rd, 5'd0);
      check("rst_rob_full", rob_full, 1'b0);
      check("rst_rs_full", rs_full, 1'b0);
      check("rst_credit_err", credit_err, 1'b0);
      acc_cyc = 0;
      for (int i = 0; i < 4; i++) begin
         send(5'd0, 5'(i + 1), 0, acc);
         check("t1_accept", acc, 1'b1);
         if (i == 0) acc_cyc = cyc;
      end
      wait_disp(4, 20, "t1_count");
      check("t1_first_latency", first_disp_cyc, acc_cyc + 1);
      check("t1_back_to_back", last_disp_cyc - first_disp_cyc, 3);
      check("t1_rs_credits", u_dut.rs_cnt, 4'd4);

      // 2: RS exhaustion -> stall, one release lets the 9th go on the following edge
      do_reset();
      for (int i = 0; i < 9; i++) begin
         send(5'(i % 12), 5'(i), 3, acc);
         check("t2_accept", acc, 1'b1);
      end
      repeat (3) step();
      check("t2_count_before", disp_cnt, 8);
      check("t2_rs_full", rs_full, 1'b1);
      check("t2_iq_ready_stall", iq_ready, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check("t2_not_yet", disp_cnt, 8);
      step();
      check("t2_ninth_issued", disp_cnt, 9);

      // 3: 16 mixed ops exhaust the ROB; commit wraps the tag to 0
      do_reset();
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 1)      send(5'(12 + i / 2), 5'(i), 3, acc);
         else if (i % 4 == 0) send(5'(i / 2), 5'(i), 3, acc);
         else                 send(5'(20 + i / 2), 5'(i), 3, acc);
         check("t3_accept", acc, 1'b1);
      end
      wait_disp(16, 20, "t3_count");
      check("t3_rob_full", rob_full, 1'b1);
      send(5'd3, 5'd20, 3, acc);
      check("t3_hold_accept", acc, 1'b1);
      repeat (3) step();
      check("t3_held", disp_cnt, 16);
      pulse(1'b1, 1'b0, 1'b1, 1'b0);
      wait_disp(17, 10, "t3_wrap_dispatch");
      check("t3_rob_full_again", rob_full, 1'b1);

      // 4: LSU op blocked on LSB credits; following ALU op may not bypass it
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send(5'(12 + i), 5'(i), 3, acc);
         check("t4_accept", acc, 1'b1);
      end
      wait_disp(8, 20, "t4_count");
      check("t4_rs_full_lsb", rs_full, 1'b1);
      check("t4_rob_not_full", rob_full, 1'b0);
      send(5'd13, 5'd9, 3, acc);
      check("t4_lsu_held", acc, 1'b1);
      send(5'd1, 5'd10, 4, acc);
      check("t4_alu_blocked", acc, 1'b0);
      check("t4_no_bypass", disp_cnt, 8);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      wait_disp(9, 10, "t4_lsu_dispatch");
      send(5'd1, 5'd10, 3, acc);
      check("t4_alu_accept", acc, 1'b1);
      wait_disp(10, 10, "t4_alu_dispatch");

      // 5: flush while stalled; a racing release is discarded
      do_reset();
      for (int i = 0; i < 9; i++) begin
         send(5'd2, 5'(i), 3, acc);
         check("t5_accept", acc, 1'b1);
      end
      repeat (3) step();
      check("t5_stalled", iq_ready, 1'b0);
      @(negedge clk);
      flush = 1'b1; rs_release = 1'b1;
      #1;
      check("t5_rdy_flush_cycle", iq_ready, 1'b0);
      @(posedge clk);
      #1;
      flush = 1'b0; rs_release = 1'b0;
      sb.delete();
      exp_tag = 0;
      step();
      check("t5_rdy_flush_state", iq_ready, 1'b0);
      check("t5_rs_credits", u_dut.rs_cnt, 4'd8);
      check("t5_rob_full", rob_full, 1'b0);
      check("t5_rs_full", rs_full, 1'b0);
      check("t5_no_err", credit_err, 1'b0);
      check("t5_dsp_valid", dsp_valid, 1'b0);
      step();
      check("t5_rdy_run", iq_ready, 1'b1);
      send(5'd5, 5'd7, 3, acc);
      check("t5_accept_after", acc, 1'b1);
      wait_disp(9, 10, "t5_dispatch_tag0");

      // 6: pause with releases; then an over-release sets a sticky error
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send(5'd4, 5'(i), 3, acc);
         check("t6_accept", acc, 1'b1);
      end
      wait_disp(3, 10, "t6_count");
      repeat (2) step();
      check("t6_rs_before", u_dut.rs_cnt, 4'd5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pause = 1'b1; rs_release = 1'b1; iq_valid = 1'b1; iq_op = 5'd0;
         #1;
         check("t6_pause_ready", iq_ready, 1'b0);
         check("t6_pause_dsp", dsp_valid, 1'b0);
      end
      @(negedge clk);
      pause = 1'b0; rs_release = 1'b0; iq_valid = 1'b0; iq_op = NOP;
      #2;
      check("t6_rs_after", u_dut.rs_cnt, 4'd8);
      check("t6_no_dispatch", disp_cnt, 3);
      check("t6_err_clear", credit_err, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check("t6_err_set", credit_err, 1'b1);
      check("t6_rs_at_max", u_dut.rs_cnt, 4'd8);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) step();
      check("t6_err_sticky", credit_err, 1'b1);
      do_reset();
      check("t6_err_reset", credit_err, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

endmodule
